// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg
//    Shared constants, state encoding and helpers for the 16-way round-robin
//    arbiter (rr_arbiter_16) and its winner picker (rr_pick).
package rr_arb_pkg;

   localparam int N     = 16;   // number of requesters
   localparam int IDX_W = 4;    // log2(N), width of an index / pointer

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index to one-hot conversion used for grant and exclusion masks.
   function automatic logic [N-1:0] onehot16(input logic [IDX_W-1:0] idx);
      onehot16 = {{(N-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//    Combinational round-robin winner search.
//    Ports:
//       req   [15:0]  request lines
//       ptr   [3:0]   index that has highest priority for this search
//       excl  [15:0]  requesters removed from consideration
//       found         a winner exists
//       idx   [3:0]   winner index (valid only when found=1)
//    The masked request vector is rotated so that bit ptr lands on bit 0,
//    the lowest set bit is located, and the position is rotated back.
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N-1:0]     excl,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N-1:0]     masked_s;
   logic [2*N-1:0]   dbl_s;
   logic [N-1:0]     rot_s;
   logic [IDX_W-1:0] pos_s;

   assign masked_s = req & ~excl;
   // Duplicating the vector turns the rotate-right into a plain shift.
   assign dbl_s    = {masked_s, masked_s} >> ptr;
   assign rot_s    = dbl_s[N-1:0];

   // Find-first-set on the rotated vector; scanning downward leaves the lowest hit.
   always_comb begin
      found = 1'b0;
      pos_s = {IDX_W{1'b0}};
      for (int i = N-1; i >= 0; i--) begin
         found = found | rot_s[i];
         pos_s = rot_s[i] ? IDX_W'(i) : pos_s;
      end
   end

   // Un-rotate: modulo-16 add wraps naturally in IDX_W bits.
   assign idx = pos_s + ptr;

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16
//    Registered 16-way round-robin arbiter feeding a 16-to-4 one-hot encoder.
//    Ports:
//       clk          rising-edge clock
//       rst          asynchronous active-high reset
//       req  [15:0]  level-sensitive request lines
//       rel          holder is done (the natural name "release" is a reserved
//                    word in SystemVerilog); ignored while idle
//       grant [15:0] registered one-hot grant, zero when idle
//       grant_valid  registered, equals |grant
//       ptr  [3:0]   round-robin start index (debug visibility)
//    A grant is held until rel=1 or the holder drops its request. At that edge
//    the pointer moves past the holder and the remaining requesters are
//    searched immediately, so back-to-back grants have no idle bubble.
module rr_arbiter_16
   import rr_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             rel,
   output logic [N-1:0]     grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] ptr
);

   state_t           state_r, state_s;
   logic [N-1:0]     grant_r, grant_s;
   logic             gv_r, gv_s;
   logic [IDX_W-1:0] ptr_r, ptr_s;
   logic [IDX_W-1:0] holder_r, holder_s;
   logic [IDX_W-1:0] holder_inc_s;
   logic [IDX_W-1:0] pick_ptr_s;
   logic [N-1:0]     excl_s;
   logic             end_s;
   logic             found_s;
   logic [IDX_W-1:0] pick_idx_s;

   // Explicit and implicit release collapse into one end-of-grant event.
   assign end_s        = (state_r == GRANT) && (rel || !req[holder_r]);
   assign holder_inc_s = holder_r + IDX_W'(1);
   // On end of grant, search from the updated pointer with the old holder masked.
   assign pick_ptr_s   = end_s ? holder_inc_s : ptr_r;
   assign excl_s       = end_s ? onehot16(holder_r) : {N{1'b0}};

   rr_pick u_pick (
      .req   (req),
      .ptr   (pick_ptr_s),
      .excl  (excl_s),
      .found (found_s),
      .idx   (pick_idx_s)
   );

   // Next-state, next-grant and pointer update.
   always_comb begin
      state_s  = state_r;
      grant_s  = grant_r;
      gv_s     = gv_r;
      ptr_s    = ptr_r;
      holder_s = holder_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s  = GRANT;
               grant_s  = onehot16(pick_idx_s);
               gv_s     = 1'b1;
               holder_s = pick_idx_s;
            end else begin
               state_s  = IDLE;
               grant_s  = {N{1'b0}};
               gv_s     = 1'b0;
            end
         end
         GRANT: begin
            if (end_s) begin
               ptr_s = holder_inc_s;
               if (found_s) begin
                  state_s  = GRANT;
                  grant_s  = onehot16(pick_idx_s);
                  gv_s     = 1'b1;
                  holder_s = pick_idx_s;
               end else begin
                  state_s  = IDLE;
                  grant_s  = {N{1'b0}};
                  gv_s     = 1'b0;
               end
            end else begin
               state_s = GRANT;
            end
         end
         default: begin
            state_s  = IDLE;
            grant_s  = {N{1'b0}};
            gv_s     = 1'b0;
            ptr_s    = {IDX_W{1'b0}};
            holder_s = {IDX_W{1'b0}};
         end
      endcase
   end

   // State, grant, pointer and holder registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         grant_r  <= {N{1'b0}};
         gv_r     <= 1'b0;
         ptr_r    <= {IDX_W{1'b0}};
         holder_r <= {IDX_W{1'b0}};
      end else begin
         state_r  <= state_s;
         grant_r  <= grant_s;
         gv_r     <= gv_s;
         ptr_r    <= ptr_s;
         holder_r <= holder_s;
      end
   end

   assign grant       = grant_r;
   assign grant_valid = gv_r;
   assign ptr         = ptr_r;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16
//    Directed testbench for rr_arbiter_16. Inputs change on the falling edge,
//    outputs are sampled on the falling edge after each rising edge.
module tb_rr_arbiter_16;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic        rel;
   logic [15:0] grant;
   logic        grant_valid;
   logic [3:0]  ptr;

   int vectors;
   int errors;

   rr_arbiter_16 dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .rel         (rel),
      .grant       (grant),
      .grant_valid (grant_valid),
      .ptr         (ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] g, input logic gv, input logic [3:0] p);
      chk({tag, ".grant"}, grant, g);
      chk({tag, ".valid"}, {15'd0, grant_valid}, {15'd0, gv});
      chk({tag, ".ptr"}, {12'd0, ptr}, {12'd0, p});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      rst = 1'b1;
      req = 16'h0000;
      rel = 1'b0;
      #1;
      chk_out("reset", 16'h0000, 1'b0, 4'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk_out("idle", 16'h0000, 1'b0, 4'd0);

      // Single request, explicit release with req still high: holder excluded.
      req = 16'h0001;
      step();
      chk_out("single.grant", 16'h0001, 1'b1, 4'd0);
      rel = 1'b1;
      step();
      chk_out("single.release", 16'h0000, 1'b0, 4'd1);
      req = 16'h0000;
      rel = 1'b0;
      step();
      chk_out("single.idle", 16'h0000, 1'b0, 4'd1);

      // Asynchronous reset mid-grant, between clock edges.
      req = 16'h0004;
      step();
      chk_out("prereset.grant", 16'h0004, 1'b1, 4'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.grant", grant, 16'h0000);
      chk("async_rst.valid", {15'd0, grant_valid}, 16'h0000);
      req = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      step();
      chk_out("postreset", 16'h0000, 1'b0, 4'd0);

      // Two requesters at opposite ends, release each grant.
      req = 16'h8001;
      step();
      chk_out("pair.0", 16'h0001, 1'b1, 4'd0);
      rel = 1'b1;
      step();
      chk_out("pair.1", 16'h8000, 1'b1, 4'd1);
      step();
      chk_out("pair.2", 16'h0001, 1'b1, 4'd0);
      step();
      chk_out("pair.3", 16'h8000, 1'b1, 4'd1);
      req = 16'h0000;
      step();
      chk_out("pair.end", 16'h0000, 1'b0, 4'd0);

      // All requesting, release every cycle: full rotation and wrap.
      req = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         step();
         chk_out($sformatf("all.%0d", i), 16'h0001 << i, 1'b1, (i == 0) ? 4'd0 : 4'(i));
      end
      step();
      chk_out("all.wrap", 16'h0001, 1'b1, 4'd0);
      req = 16'h0000;
      step();
      chk_out("all.end", 16'h0000, 1'b0, 4'd1);
      rel = 1'b0;

      // Implicit release by dropping the holder's request.
      req = 16'h0014;
      step();
      chk_out("implicit.grant", 16'h0004, 1'b1, 4'd1);
      req = 16'h0010;
      step();
      chk_out("implicit.switch", 16'h0010, 1'b1, 4'd3);
      req = 16'h0000;
      step();
      chk_out("implicit.end", 16'h0000, 1'b0, 4'd5);

      // No pre-emption while held, then release picks next in rotated order.
      req = 16'h0002;
      step();
      chk_out("hold.grant", 16'h0002, 1'b1, 4'd5);
      req = 16'h0023;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out($sformatf("hold.%0d", i), 16'h0002, 1'b1, 4'd5);
      end
      rel = 1'b1;
      step();
      chk_out("hold.release", 16'h0020, 1'b1, 4'd2);
      req = 16'h0000;
      step();
      chk_out("hold.end", 16'h0000, 1'b0, 4'd6);
      rel = 1'b0;
      step();
      chk_out("final.idle", 16'h0000, 1'b0, 4'd6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Registered 16-way round-robin arbiter that sits directly upstream of the 16-to-4 one-hot encoder.
- Collects up to 16 request lines and issues exactly one one-hot grant, held until the winner releases it.
- grant drives the encoder data input; grant_valid drives the encoder enable.
- Guarantees the encoder only ever sees a legal one-hot code or all-zero.

Parameters:
- N, 16, number of requesters; fixed at 16 for this block, present for package consistency.
- IDX_W, 4, width of the internal priority pointer, equal to log2(N).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request lines; bit i is requester i; level-sensitive.
- release  input  1  current grant holder is done; sampled only while grant_valid=1.
- grant  output  16  registered one-hot grant, or 16'h0000 when idle.
- grant_valid  output  1  high when grant is non-zero; registered.
- ptr  output  4  current round-robin start index; debug and verification visibility.

Behaviour:
- Reset (asynchronous, immediate, no clock needed): grant=16'h0000, grant_valid=0, ptr=0, state=IDLE.
- States:
  - IDLE: grant_valid=0.
  - GRANT: grant_valid=1 and grant holds one winner.
- Winner selection (combinational):
  - Scan req starting at index ptr, ascending, wrapping from 15 to 0.
  - The first set bit wins.
  - Lowest index wins only relative to the rotated order.
- IDLE -> GRANT: at the first rising edge where req!=0.
  - grant=onehot(winner), grant_valid=1.
  - Latency: one edge from req to grant.
- GRANT, hold: grant remains stable while release=0 and req[holder]=1.
  - New requests arriving in this period do not pre-empt the holder.
- GRANT, end of grant: release=1, or req[holder]=0 (implicit release). At that edge:
  - ptr <= holder+1 mod 16; holder 15 wraps ptr to 0.
  - Remaining requests are evaluated with the updated ptr; the old holder is excluded this edge even if it still requests.
  - If a winner exists: grant switches directly to it, stay in GRANT (back-to-back, no bubble).
  - If no winner exists: grant=0, go to IDLE.
- release while in IDLE: ignored.
- release and req[holder] dropping on the same edge: single release.
- ptr changes only when a grant ends, never on grant issue.
- Invariants:
  - grant is always one-hot or zero.
  - grant is never issued to a requester whose req was 0 at the granting edge.
  - grant_valid == |grant.
- Reset during GRANT: grant cleared asynchronously; the pending release is lost; the first post-reset grant scans from index 0.

Decomposition:
- Package rr_arb_pkg holds:
  - Constants N=16 and IDX_W=4.
  - State enum {IDLE, GRANT}.
  - Function onehot16(idx).
- One combinational sub-module rr_pick. Inputs: req[15:0], ptr[3:0], exclude-mask. Outputs: found and idx[3:0]. Implemented as rotate, find-first, un-rotate.
- The top level holds the state register, grant register and ptr register.

Test Plan:
- Assert rst mid-simulation without a clock edge -> grant=0000 and grant_valid=0 immediately; ptr=0 after rst deasserts.
- From reset, req=0x0001 -> after edge 1 grant=0x0001 and grant_valid=1; pulse release -> next edge grant=0x0000, grant_valid=0, ptr=1.
- req=0x8001 held, release pulsed each grant -> grant sequence 0x0001, 0x8000, 0x0001, 0x8000 with no idle cycles.
- req=0xFFFF held, release every cycle -> grants 0x0001, 0x0002, ..., 0x8000, then 0x0001 (ptr wraps 15->0).
- Holder 0x0004 granted with req=0x0014; drop req[2] with release=0 -> next edge grant=0x0010 and ptr=3.
- Holder 0x0002 granted; raise req[0] and req[5] with release=0 for 10 cycles -> grant stays 0x0002; then release -> grant=0x0020.
